// File: rtl/load_store_unit.sv
// load_store_unit: accepts one pipeline op at a time and either writes the ALU
// result straight back (pass) or performs a single-word memory read/write with
// a request/grant handshake, then emits a one-cycle writeback pulse.
// A wait counter aborts requests that stall for TIMEOUT cycles and sets a
// sticky err flag.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        op handshake (ready only in IDLE)
//   in_op/in_result/in_rd/in_dst  op code, ALU result / address, store data, dest reg
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//   mem_gnt/mem_rvalid/mem_rdata       memory grant and read response
//   wb_valid/wb_en/wb_data/wb_dst      registered writeback pulse
//   err                      sticky timeout flag
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [15:0] in_result,
  input  logic [15:0] in_rd,
  input  logic [2:0]  in_dst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [15:0] wb_data,
  output logic [2:0]  wb_dst,
  output logic        err
);

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 3;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [1:0]    OP_LOAD   = 2'b01;
  localparam logic [1:0]    OP_STORE  = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_op, w_op_nxt;
  logic [RW-1:0] r_dst, w_dst_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_mem_req, w_mem_req_nxt;
  logic          r_mem_we, w_mem_we_nxt;
  logic [DW-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic          r_wb_valid, w_wb_valid_nxt;
  logic          r_wb_en, w_wb_en_nxt;
  logic [DW-1:0] r_wb_data, w_wb_data_nxt;
  logic [RW-1:0] r_wb_dst, w_wb_dst_nxt;
  logic          r_err, w_err_nxt;

  logic [CW-1:0] w_cnt_inc;
  logic          w_timeout;
  logic          w_is_mem_op;

  // Saturating wait counter; timeout fires on the cycle the count would reach TIMEOUT.
  assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
  assign w_timeout   = (w_cnt_inc >= TIMEOUT_C);
  assign w_is_mem_op = (in_op == OP_LOAD) || (in_op == OP_STORE);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_op        <= 2'b00;
      r_dst       <= '0;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_en     <= 1'b0;
      r_wb_data   <= '0;
      r_wb_dst    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_dst       <= w_dst_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_wb_valid  <= w_wb_valid_nxt;
      r_wb_en     <= w_wb_en_nxt;
      r_wb_data   <= w_wb_data_nxt;
      r_wb_dst    <= w_wb_dst_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_dst_nxt       = r_dst;
    w_cnt_nxt       = r_cnt;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_wb_valid_nxt  = 1'b0;
    w_wb_en_nxt     = 1'b0;
    w_wb_data_nxt   = r_wb_data;
    w_wb_dst_nxt    = r_wb_dst;
    w_err_nxt       = r_err;

    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_op_nxt  = in_op;
          w_dst_nxt = in_dst;
          if (w_is_mem_op) begin
            w_mem_addr_nxt  = in_result;
            w_mem_wdata_nxt = in_rd;
            w_mem_we_nxt    = (in_op == OP_STORE);
            w_mem_req_nxt   = 1'b1;
            w_cnt_nxt       = '0;
            w_state_nxt     = REQ;
          end else begin
            // Pass and reserved ops write the ALU result back directly.
            w_wb_valid_nxt = 1'b1;
            w_wb_en_nxt    = 1'b1;
            w_wb_data_nxt  = in_result;
            w_wb_dst_nxt   = in_dst;
          end
        end
      end

      REQ: begin
        if (mem_gnt) begin
          w_mem_req_nxt = 1'b0;
          if (r_op == OP_STORE) begin
            w_wb_valid_nxt = 1'b1;
            w_wb_data_nxt  = r_mem_addr;
            w_wb_dst_nxt   = r_dst;
            w_state_nxt    = IDLE;
          end else if (mem_rvalid) begin
            // Zero-wait read: grant and data together, skip WAIT.
            w_wb_valid_nxt = 1'b1;
            w_wb_en_nxt    = 1'b1;
            w_wb_data_nxt  = mem_rdata;
            w_wb_dst_nxt   = r_dst;
            w_state_nxt    = IDLE;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = WAIT;
          end
        end else if (w_timeout) begin
          w_err_nxt     = 1'b1;
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      WAIT: begin
        if (mem_rvalid) begin
          w_wb_valid_nxt = 1'b1;
          w_wb_en_nxt    = 1'b1;
          w_wb_data_nxt  = mem_rdata;
          w_wb_dst_nxt   = r_dst;
          w_state_nxt    = IDLE;
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign wb_valid  = r_wb_valid;
  assign wb_en     = r_wb_en;
  assign wb_data   = r_wb_data;
  assign wb_dst    = r_wb_dst;
  assign err       = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit (built with TIMEOUT=4).
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [15:0] in_result;
  logic [15:0] in_rd;
  logic [2:0]  in_dst;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        wb_valid;
  logic        wb_en;
  logic [15:0] wb_data;
  logic [2:0]  wb_dst;
  logic        err;

  int n_checks;
  int n_errors;

  logic [15:0] mem [64];

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_result (in_result),
    .in_rd     (in_rd),
    .in_dst    (in_dst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .wb_valid  (wb_valid),
    .wb_en     (wb_en),
    .wb_data   (wb_data),
    .wb_dst    (wb_dst),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: mem[i]=i except mem[40]=0x00FF; writes on granted store.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'(i);
      mem[40] <= 16'h00FF;
    end else if (mem_req && mem_gnt && mem_we) begin
      mem[mem_addr[5:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[5:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] res,
                       input logic [15:0] rd, input logic [2:0] dst);
    in_valid  = 1'b1;
    in_op     = op;
    in_result = res;
    in_rd     = rd;
    in_dst    = dst;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_op      = 2'b00;
    in_result  = '0;
    in_rd      = '0;
    in_dst     = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;

    // Reset state
    step();
    step();
    check_eq("rst_mem_req",  32'(mem_req),  32'd0);
    check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
    check_eq("rst_err",      32'(err),      32'd0);
    check_eq("rst_addr",     32'(mem_addr), 32'd0);
    check_eq("rst_wb_data",  32'(wb_data),  32'd0);
    rst = 1'b0;
    check_eq("rel_ready",    32'(in_ready), 32'd1);

    // Load of address 23, grant after 2 cycles, rvalid one cycle later
    issue(2'b01, 16'd23, 16'd0, 3'd1);
    step();
    in_valid = 1'b0;
    check_eq("ld_req",   32'(mem_req),  32'd1);
    check_eq("ld_we",    32'(mem_we),   32'd0);
    check_eq("ld_addr",  32'(mem_addr), 32'd23);
    check_eq("ld_ready", 32'(in_ready), 32'd0);
    step();
    check_eq("ld_req_hold", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check_eq("ld_wait_req", 32'(mem_req),  32'd0);
    check_eq("ld_wait_wb",  32'(wb_valid), 32'd0);
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    check_eq("ld_wb_valid", 32'(wb_valid), 32'd1);
    check_eq("ld_wb_en",    32'(wb_en),    32'd1);
    check_eq("ld_wb_data",  32'(wb_data),  32'd23);
    check_eq("ld_wb_dst",   32'(wb_dst),   32'd1);
    step();
    check_eq("ld_wb_pulse", 32'(wb_valid), 32'd0);

    // Store 10 to address 23; rvalid during store must be ignored
    issue(2'b10, 16'd23, 16'd10, 3'd2);
    step();
    in_valid = 1'b0;
    check_eq("st_we",    32'(mem_we),    32'd1);
    check_eq("st_addr",  32'(mem_addr),  32'd23);
    check_eq("st_wdata", 32'(mem_wdata), 32'd10);
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    check_eq("st_req_hold", 32'(mem_req),   32'd1);
    check_eq("st_no_wb",    32'(wb_valid),  32'd0);
    check_eq("st_wd_hold",  32'(mem_wdata), 32'd10);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check_eq("st_req_drop", 32'(mem_req),  32'd0);
    check_eq("st_wb_valid", 32'(wb_valid), 32'd1);
    check_eq("st_wb_en",    32'(wb_en),    32'd0);
    check_eq("st_wb_data",  32'(wb_data),  32'd23);
    // Read back
    issue(2'b01, 16'd23, 16'd0, 3'd3);
    step();
    in_valid = 1'b0;
    mem_gnt  = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    check_eq("rb_wb_valid", 32'(wb_valid), 32'd1);
    check_eq("rb_wb_data",  32'(wb_data),  32'd10);
    check_eq("rb_wb_dst",   32'(wb_dst),   32'd3);

    // Three back-to-back pass ops (last uses reserved opcode)
    issue(2'b00, 16'd30, 16'd0, 3'd4);
    step();
    check_eq("p0_valid", 32'(wb_valid), 32'd1);
    check_eq("p0_data",  32'(wb_data),  32'd30);
    check_eq("p0_req",   32'(mem_req),  32'd0);
    check_eq("p0_ready", 32'(in_ready), 32'd1);
    issue(2'b00, 16'd31, 16'd0, 3'd5);
    step();
    check_eq("p1_valid", 32'(wb_valid), 32'd1);
    check_eq("p1_data",  32'(wb_data),  32'd31);
    issue(2'b11, 16'd32, 16'd0, 3'd6);
    step();
    in_valid = 1'b0;
    check_eq("p2_valid", 32'(wb_valid), 32'd1);
    check_eq("p2_data",  32'(wb_data),  32'd32);
    check_eq("p2_en",    32'(wb_en),    32'd1);
    check_eq("p2_dst",   32'(wb_dst),   32'd6);
    check_eq("p2_req",   32'(mem_req),  32'd0);
    step();
    check_eq("p_end", 32'(wb_valid), 32'd0);

    // Zero-wait load: grant and rvalid together
    issue(2'b01, 16'd40, 16'd0, 3'd7);
    step();
    in_valid   = 1'b0;
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    check_eq("zw_valid", 32'(wb_valid), 32'd1);
    check_eq("zw_data",  32'(wb_data),  32'h00FF);
    check_eq("zw_dst",   32'(wb_dst),   32'd7);
    check_eq("zw_ready", 32'(in_ready), 32'd1);

    // Timeout: no grant for 4 REQ cycles
    issue(2'b01, 16'd5, 16'd0, 3'd1);
    step();
    in_valid = 1'b0;
    check_eq("to_req1", 32'(mem_req), 32'd1);
    step();
    step();
    step();
    check_eq("to_req4", 32'(mem_req), 32'd1);
    check_eq("to_err4", 32'(err),     32'd0);
    step();
    check_eq("to_err",   32'(err),      32'd1);
    check_eq("to_req",   32'(mem_req),  32'd0);
    check_eq("to_wb",    32'(wb_valid), 32'd0);
    check_eq("to_ready", 32'(in_ready), 32'd1);
    issue(2'b00, 16'h1234, 16'd0, 3'd2);
    step();
    in_valid = 1'b0;
    check_eq("to_pass_valid", 32'(wb_valid), 32'd1);
    check_eq("to_pass_data",  32'(wb_data),  32'h1234);
    check_eq("to_err_sticky", 32'(err),      32'd1);

    // Reset while in WAIT, then a late rvalid
    issue(2'b01, 16'd23, 16'd0, 3'd1);
    step();
    in_valid = 1'b0;
    mem_gnt  = 1'b1;
    step();
    mem_gnt = 1'b0;
    rst     = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mr_req",   32'(mem_req),  32'd0);
    check_eq("mr_wb",    32'(wb_valid), 32'd0);
    check_eq("mr_err",   32'(err),      32'd0);
    check_eq("mr_ready", 32'(in_ready), 32'd1);
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    check_eq("mr_late_rv", 32'(wb_valid), 32'd0);
    check_eq("mr_ready2",  32'(in_ready), 32'd1);
    check_eq("mr_req2",    32'(mem_req),  32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles waiting for mem_gnt or mem_rvalid before abort.
REQ-002 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: pipeline presents an op.
REQ-005 SHALL have port in_ready, output, 1: unit accepts op this cycle.
REQ-006 SHALL have port in_op, input, 2: 00 pass, 01 load, 10 store, 11 reserved (treated as pass).
REQ-007 SHALL have port in_result, input, 16: ALU result, also the memory address for load/store.
REQ-008 SHALL have port in_rd, input, 16: store data.
REQ-009 SHALL have port in_dst, input, 3: destination register index.
REQ-010 SHALL have port mem_req, output, 1: memory request.
REQ-011 SHALL have port mem_we, output, 1: 1 write, 0 read.
REQ-012 SHALL have port mem_addr, output, 16: word address.
REQ-013 SHALL have port mem_wdata, output, 16: write data.
REQ-014 SHALL have port mem_gnt, input, 1: memory accepted request.
REQ-015 SHALL have port mem_rvalid, input, 1: read data valid.
REQ-016 SHALL have port mem_rdata, input, 16: read data.
REQ-017 SHALL have port wb_valid, output, 1: one-cycle writeback pulse.
REQ-018 SHALL have port wb_en, output, 1: register write enable qualifying wb_valid.
REQ-019 SHALL have port wb_data, output, 16: writeback value.
REQ-020 SHALL have port wb_dst, output, 3: writeback register index.
REQ-021 SHALL have port err, output, 1: sticky timeout flag.

Function
REQ-022 SHALL implement FSM states IDLE, REQ, WAIT, and no others.
REQ-023 SHALL drive in_ready=1 only in IDLE; an op is accepted when in_valid && in_ready.
REQ-024 SHALL register in_op, in_result, in_rd, and in_dst on acceptance; memory outputs come from registers only.
REQ-025 For an accepted pass op, SHALL pulse, on the next cycle, wb_valid=1, wb_en=1, wb_data=in_result, wb_dst=in_dst, and remain in IDLE (1-cycle latency, back-to-back accepts allowed).
REQ-026 For an accepted load or store op, SHALL go to REQ, holding mem_req=1, mem_addr=result, and mem_we (1 for store), with mem_wdata=rd for store; these stay stable until mem_gnt.
REQ-027 For a store in REQ with mem_gnt=1, SHALL drop mem_req next cycle, pulse wb_valid=1 with wb_en=0 and wb_data=address, and return to IDLE.
REQ-028 For a load in REQ with mem_gnt=1 and mem_rvalid=0, SHALL go to WAIT with mem_req=0.
REQ-029 For a load in REQ with mem_gnt=1 and mem_rvalid=1 in the same cycle, SHALL complete as in REQ-030, skipping WAIT.
REQ-030 On load completion, in WAIT with mem_rvalid=1, SHALL capture mem_rdata and pulse wb_valid=1, wb_en=1, wb_data=rdata, wb_dst next cycle, then go to IDLE.
REQ-031 SHALL ignore mem_rvalid in IDLE, in REQ before gnt, and for stores.
REQ-032 SHALL keep wb_valid=0 in every cycle not named in REQ-025/027/030.
REQ-033 SHALL use an 8-bit wait counter cleared on entry to REQ and to WAIT, incremented each cycle in those states, and saturating.
REQ-034 When the counter reaches TIMEOUT in REQ or WAIT, SHALL set err=1, drop mem_req, emit no wb_valid, and return to IDLE.
REQ-035 SHALL keep err set until reset; subsequent ops still execute normally.

Reset
REQ-036 On rst=1 at a clock edge, SHALL go to IDLE and clear mem_req, mem_we, wb_valid, wb_en, and err to 0, and mem_addr, mem_wdata, wb_data, wb_dst, and the counter to 0.
REQ-037 Reset in REQ or WAIT SHALL abandon the op with no writeback, and SHALL drop mem_req by the first cycle after the reset edge.
REQ-038 in_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-039 Load: memory preloaded so mem[i]=i, accept load with result=23, dst=1, gnt after 2 cycles, rvalid 1 cycle later -> mem_addr=23, mem_we=0, then wb_valid, wb_en=1, wb_data=23, wb_dst=1.
REQ-040 Store: accept store with result=23, rd=10 -> mem_we=1, mem_addr=23, mem_wdata=10 until gnt; wb_en=0; a following load of 23 returns 10.
REQ-041 Pass: three back-to-back pass ops with result=30, 31, 32 -> wb_valid on 3 consecutive cycles with wb_data=30, 31, 32; mem_req stays 0.
REQ-042 Zero-wait load: gnt and rvalid in the same cycle as mem_req with rdata=0x00FF -> no WAIT cycle; wb_data=0x00FF on the next cycle.
REQ-043 Timeout: TIMEOUT=4 and gnt never asserted -> err=1 and mem_req=0 after 4 REQ cycles, no wb_valid; the next pass op still writes back.
REQ-044 Reset mid-load: assert rst in WAIT -> next cycle mem_req=0, wb_valid=0, err=0, in_ready=1 after release; a late rvalid is ignored.
